ysyx_22041207_if_id_queue: RTL
==============================

YSYX_22041207_IF_ID_QUEUE -- requirements
Module: ysyx_22041207_if_id_queue

Interface
REQ-001 Parameter DEPTH, 2, number of buffered fetch entries; power of two, >= 2.
REQ-002 Parameter CNT_W, 32, width of flush event counter.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  fetch stage presents an instruction.
REQ-006 in_pc  input  64  PC of presented instruction.
REQ-007 in_inst  input  32  presented instruction word.
REQ-008 in_ready  output  1  queue accepts a push this cycle; IF holds its PC when low.
REQ-009 flush  input  1  EX redirect (jal, jalr, taken branch): discard all queued and incoming entries.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_pc  output  64  head entry PC.
REQ-012 out_inst  output  32  head entry instruction.
REQ-013 out_misalign  output  1  head entry PC has bits [1:0] != 0.
REQ-014 out_ready  input  1  decode consumes head this cycle.
REQ-015 flush_cnt  output  CNT_W  number of cycles with flush asserted since reset, saturating.

Function
REQ-016 State SHALL be: storage[DEPTH] of {pc, inst, misalign}, rd_ptr, wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH).
REQ-017 in_ready SHALL equal (count != DEPTH), derived from registered state only; no combinational path from out_ready or flush.
REQ-018 out_valid SHALL equal (count != 0); out_pc/out_inst/out_misalign SHALL show storage[rd_ptr] when valid, all zero when empty.
REQ-019 push = in_valid & in_ready & ~flush; writes {in_pc, in_inst, in_pc[1:0]!=0} at wr_ptr, wr_ptr+1.
REQ-020 pop = out_valid & out_ready & ~flush; rd_ptr+1.
REQ-021 count next = count + push - pop; push and pop in one cycle leave count unchanged, legal even when full is false and empty is false.
REQ-022 Full with out_ready high: pop occurs, push refused that cycle (in_ready already low); no same-cycle bypass.
REQ-023 Empty with in_valid high: entry becomes visible on out_* the following cycle; minimum latency 1 cycle, no combinational bypass.
REQ-024 flush SHALL win over push and pop: next cycle count=0, rd_ptr=wr_ptr=0, out_valid=0; the concurrent in_* entry is dropped.
REQ-025 flush_cnt SHALL increment by 1 each cycle flush is high, holding at 2^CNT_W-1.
REQ-026 Storage contents not at a valid position are don't-care but SHALL never reach out_* (zero-masked).
REQ-027 out_* SHALL remain stable while out_valid & ~out_ready & ~flush.
REQ-028 Entries SHALL leave in push order (FIFO), across pointer wrap-around.

Reset
REQ-029 On rst high at a rising edge: count, rd_ptr, wr_ptr, flush_cnt = 0; out_valid = 0; out_* = 0; in_ready = 1 the following cycle.
REQ-030 rst SHALL override flush, push and pop in the same cycle; reset mid-operation discards all entries.

Structure
REQ-031 Shared package ysyx_22041207_pkg SHALL hold XLEN=64, ILEN=32, RESET_PC=64'h80000000 and the fetch-entry struct {pc, inst, misalign}.
REQ-032 Storage array with write port and indexed read SHALL be one sub-module ysyx_22041207_fifo_mem; pointer/count control stays in the top.

Verification
REQ-033 Reset, then push pc=0x80000000 inst=0x00000513 with out_ready=0 -> next cycle out_valid=1, out_pc=0x80000000, out_inst=0x00000513, count=1.
REQ-034 Push 0x80000000, 0x80000004 with out_ready=0 -> in_ready=0 after second push; third in_valid held, not accepted until a pop.
REQ-035 Full, out_ready=1 and in_valid=1 for 6 cycles with sequential PCs -> outputs 0x80000000..0x80000014 in order, no loss/duplication across wrap.
REQ-036 count=2, flush=1 with in_valid=1 pc=0x80000100 -> next cycle out_valid=0, in_ready=1, flush_cnt=1, 0x80000100 never appears.
REQ-037 Push pc=0x80000002 -> out_misalign=1 at head; rst asserted with flush=1 -> all outputs 0, flush_cnt=0.

Source files
------------

// File: rtl/ysyx_22041207_pkg.sv
// Shared core-wide constants and the fetch-entry record passed from IF to ID.
package ysyx_22041207_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic            misalign;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_22041207_fifo_mem.sv
// Fetch-entry storage: one synchronous write port, one asynchronous indexed read port.
module ysyx_22041207_fifo_mem
    import ysyx_22041207_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t  rdata
);

    // Contents need no reset: the queue masks any slot outside the valid window.
    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ysyx_22041207_if_id_queue.sv
// IF->ID decoupling queue: small FIFO of fetched instructions with flush and a
// saturating count of flush cycles. Handshake readiness comes only from registered state.
module ysyx_22041207_if_id_queue
    import ysyx_22041207_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_inst,
    output logic            in_ready,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
    output logic            out_misalign,
    input  logic            out_ready,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             push, pop;
    fetch_entry_t     wr_entry, rd_entry;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_entry          = '0;
        wr_entry.pc       = in_pc;
        wr_entry.inst     = in_inst;
        wr_entry.misalign = (in_pc[1:0] != 2'b00);
    end

    // Flush wins over push/pop and rewinds both pointers to slot 0.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    ysyx_22041207_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Stale slots must never leak to decode, so the head is zeroed when empty.
    assign out_pc       = out_valid ? rd_entry.pc       : '0;
    assign out_inst     = out_valid ? rd_entry.inst     : '0;
    assign out_misalign = out_valid ? rd_entry.misalign : 1'b0;
    assign flush_cnt    = flush_cnt_q;

endmodule
